alu_result_stage: RTL

- Execute/write-back boundary stage directly downstream of the 16-bit ALU (ops AND 000, OR 001, ADD 010, SUB 011, SLT 111).
- Captures each ALU result with its destination register and raw flags into a small in-order buffer with valid/ready handshakes.
- Presents results to the register-file write port.
- Commits architectural status flags (N/Z/C/V and LT/EQ/GT) at retirement.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/result_fifo.sv | 67 ++++++
 rtl/alu_result_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: op codes, default widths and
// the packed entry that travels through the result buffer.
package alu_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_RD_W   = 3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b111;

  // One buffered ALU result; every raw flag bit is kept even if the op
  // will not use it, so retirement sees exactly what the ALU produced.
  typedef struct packed {
    logic [2:0]            op;
    logic [DEF_RD_W-1:0]   rd;
    logic [DEF_DATA_W-1:0] z;
    logic                  c_out;
    logic                  overflow;
    logic                  lt;
    logic                  eq;
    logic                  gt;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // True for the five defined ALU ops; those are the only ones that write
  // the register file.
  function automatic logic op_writes(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// In-order result buffer: DEPTH entries, wrapping pointers, registered count.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready depends only on registered state (never on out_ready), and
// valid/data on either side stay stable until the transfer occurs.
module result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_live;   // low during reset and until the first edge after release

  logic w_push;
  logic w_pop;

  assign in_ready  = r_live && (r_count < FULL_CNT);
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Pointers, occupancy and the post-reset ready enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Execute/write-back boundary: buffers ALU results in order, drives the
// register-file write port from the head entry and commits status flags,
// the illegal-op sticky bit and the retire counter when the head retires.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_z,
  input  logic              in_c_out,
  input  logic              in_overflow,
  input  logic              in_lt,
  input  logic              in_eq,
  input  logic              in_gt,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic              flag_lt,
  output logic              flag_eq,
  output logic              flag_gt,
  output logic              illegal_op,
  output logic [15:0]       retired_cnt
);

  entry_t w_in_entry;
  entry_t w_head;
  logic   w_retire;

  logic        r_n, r_z, r_c, r_v;
  logic        r_lt, r_eq, r_gt;
  logic        r_illegal;
  logic [15:0] r_retired;

  // Pack the incoming ALU result; the entry layout follows the package widths.
  always_comb begin
    w_in_entry          = '0;
    w_in_entry.op       = in_op;
    w_in_entry.rd       = in_rd;
    w_in_entry.z        = in_z;
    w_in_entry.c_out    = in_c_out;
    w_in_entry.overflow = in_overflow;
    w_in_entry.lt       = in_lt;
    w_in_entry.eq       = in_eq;
    w_in_entry.gt       = in_gt;
  end

  result_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_entry),
    .out_valid (wb_valid),
    .out_ready (wb_ready),
    .out_data  (w_head)
  );

  assign w_retire = wb_valid && wb_ready;
  assign wb_we    = wb_valid && op_writes(w_head.op);
  assign wb_rd    = w_head.rd;
  assign wb_data  = w_head.z;

  // Commit flags from the retiring head entry; ops only touch their own flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n       <= 1'b0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_v       <= 1'b0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
      r_gt      <= 1'b0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + 16'd1;
      case (w_head.op)
        OP_AND, OP_OR: begin
          r_n <= w_head.z[DATA_W-1];
          r_z <= (w_head.z == '0);
        end
        OP_ADD, OP_SUB: begin
          r_n <= w_head.z[DATA_W-1];
          r_z <= (w_head.z == '0);
          r_c <= w_head.c_out;
          r_v <= w_head.overflow;
        end
        OP_SLT: begin
          r_lt <= w_head.lt;
          r_eq <= w_head.eq;
          r_gt <= w_head.gt;
        end
        default: r_illegal <= 1'b1;
      endcase
    end
  end

  assign flag_n      = r_n;
  assign flag_z      = r_z;
  assign flag_c      = r_c;
  assign flag_v      = r_v;
  assign flag_lt     = r_lt;
  assign flag_eq     = r_eq;
  assign flag_gt     = r_gt;
  assign illegal_op  = r_illegal;
  assign retired_cnt = r_retired;

endmodule
